// File: rtl/cache_read_data_return.sv
// cache_read_data_return
//
// Read-return path of the cache. On each accepted request it takes a full line
// (from RAM on a refill, or from the cache array on a hit), picks the CPU word
// addressed by the upper offset bits, and applies the byte-valid mask. Illegal
// masks return zero data with the error flag set. Results go into a 2-entry
// response FIFO that is drained by the CPU over a valid/ready handshake.
//
// Optional feature macro: CACHE_READ_ALIGN_EN
//   defined   - selected bytes are right-aligned to bit 0 and zero-extended
//   undefined - selected bytes stay in their lanes, disabled lanes are zeroed
//
// Ports:
//   CLK            clock, rising edge
//   RESET          synchronous, active-high reset
//   IN_REQ_VALID   read request present
//   OUT_REQ_READY  block can accept a request (FIFO not full)
//   SIG_RAM_LOAD   1: line from IN_RAM_DATA, 0: line from IN_CACHE_DATA
//   IN_ADDR_OFFSET byte offset in the line; upper half selects the word
//   IN_B_VAL       byte-valid mask
//   IN_RAM_DATA    refill line
//   IN_CACHE_DATA  cache array line
//   OUT_CPU_VALID  response valid (FIFO not empty)
//   IN_CPU_READY   CPU consumes the response
//   OUT_CPU_DATA   response word (head entry)
//   OUT_CPU_ERR    illegal-mask flag for the head entry
module cache_read_data_return #(
  parameter int unsigned CPU_DATA_SIZE    = 32,
  parameter int unsigned RAM_DATA_SIZE    = 128,
  parameter int unsigned ADDR_OFFSET_SIZE = 4,
  parameter int unsigned B_VAL_SIZE       = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        IN_REQ_VALID,
  output logic                        OUT_REQ_READY,
  input  logic                        SIG_RAM_LOAD,
  input  logic [ADDR_OFFSET_SIZE-1:0] IN_ADDR_OFFSET,
  input  logic [B_VAL_SIZE-1:0]       IN_B_VAL,
  input  logic [RAM_DATA_SIZE-1:0]    IN_RAM_DATA,
  input  logic [RAM_DATA_SIZE-1:0]    IN_CACHE_DATA,
  output logic                        OUT_CPU_VALID,
  input  logic                        IN_CPU_READY,
  output logic [CPU_DATA_SIZE-1:0]    OUT_CPU_DATA,
  output logic                        OUT_CPU_ERR
);

  localparam int unsigned WordSelW = ADDR_OFFSET_SIZE - ADDR_OFFSET_SIZE / 2;
  localparam int unsigned EntryW   = CPU_DATA_SIZE + 1;

  localparam logic [B_VAL_SIZE-1:0] MaskB0     = B_VAL_SIZE'(4'b0001);
  localparam logic [B_VAL_SIZE-1:0] MaskB1     = B_VAL_SIZE'(4'b0010);
  localparam logic [B_VAL_SIZE-1:0] MaskB2     = B_VAL_SIZE'(4'b0100);
  localparam logic [B_VAL_SIZE-1:0] MaskB3     = B_VAL_SIZE'(4'b1000);
  localparam logic [B_VAL_SIZE-1:0] MaskHalfLo = B_VAL_SIZE'(4'b0011);
  localparam logic [B_VAL_SIZE-1:0] MaskHalfHi = B_VAL_SIZE'(4'b1100);
  localparam logic [B_VAL_SIZE-1:0] MaskAll    = B_VAL_SIZE'(4'b1111);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e state_q, state_d;
  logic [EntryW-1:0] head_q, head_d;
  logic [EntryW-1:0] tail_q, tail_d;

  // ---------------------------------------------------------------------------
  // Word select and byte masking
  // ---------------------------------------------------------------------------
  logic [RAM_DATA_SIZE-1:0] line;
  logic [WordSelW-1:0]      word_sel;
  logic [CPU_DATA_SIZE-1:0] sel_word;
  logic [CPU_DATA_SIZE-1:0] masked_word;
  logic [CPU_DATA_SIZE-1:0] aligned_word;
  logic                     mask_legal;
  logic [EntryW-1:0]        push_entry;

  // Lower offset bits address bytes inside the word; masking covers them.
  logic unused_offset_lo;
  assign unused_offset_lo = ^IN_ADDR_OFFSET[ADDR_OFFSET_SIZE/2-1:0];

  assign line     = SIG_RAM_LOAD ? IN_RAM_DATA : IN_CACHE_DATA;
  assign word_sel = IN_ADDR_OFFSET[ADDR_OFFSET_SIZE-1:ADDR_OFFSET_SIZE/2];
  assign sel_word = line[int'(word_sel) * CPU_DATA_SIZE +: CPU_DATA_SIZE];

  always_comb begin
    mask_legal = 1'b0;
    case (IN_B_VAL)
      MaskB0, MaskB1, MaskB2, MaskB3,
      MaskHalfLo, MaskHalfHi, MaskAll: mask_legal = 1'b1;
      default:                         mask_legal = 1'b0;
    endcase
  end

  always_comb begin
    masked_word = '0;
    for (int i = 0; i < int'(B_VAL_SIZE); i++) begin
      masked_word[i*8 +: 8] = IN_B_VAL[i] ? sel_word[i*8 +: 8] : 8'h00;
    end
  end

`ifdef CACHE_READ_ALIGN_EN
  // Byte index of the lowest enabled lane; shifting by it lands the data at bit 0.
  logic [1:0] align_shift;

  always_comb begin
    align_shift = 2'd0;
    case (IN_B_VAL)
      MaskB1:             align_shift = 2'd1;
      MaskB2, MaskHalfHi: align_shift = 2'd2;
      MaskB3:             align_shift = 2'd3;
      default:            align_shift = 2'd0;
    endcase
  end

  assign aligned_word = masked_word >> (8 * int'(align_shift));
`else
  assign aligned_word = masked_word;
`endif

  assign push_entry = mask_legal ? {1'b0, aligned_word} : {1'b1, {CPU_DATA_SIZE{1'b0}}};

  // ---------------------------------------------------------------------------
  // Response FIFO: head register drives the outputs directly, tail holds the
  // second entry. Keeping the head in place on a pop to EMPTY gives the
  // "hold last value" behaviour for free.
  // ---------------------------------------------------------------------------
  logic accept;
  logic pop;

  assign OUT_REQ_READY = (state_q != StFull);
  assign OUT_CPU_VALID = (state_q != StEmpty);
  assign OUT_CPU_DATA  = head_q[CPU_DATA_SIZE-1:0];
  assign OUT_CPU_ERR   = head_q[CPU_DATA_SIZE];

  assign accept = IN_REQ_VALID & OUT_REQ_READY;
  assign pop    = OUT_CPU_VALID & IN_CPU_READY;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          head_d  = push_entry;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && pop) begin
          head_d = push_entry;
        end else if (accept) begin
          tail_d  = push_entry;
          state_d = StFull;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_cache_read_data_return.sv
module tb_cache_read_data_return;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         IN_REQ_VALID;
  logic         OUT_REQ_READY;
  logic         SIG_RAM_LOAD;
  logic [3:0]   IN_ADDR_OFFSET;
  logic [3:0]   IN_B_VAL;
  logic [127:0] IN_RAM_DATA;
  logic [127:0] IN_CACHE_DATA;
  logic         OUT_CPU_VALID;
  logic         IN_CPU_READY;
  logic [31:0]  OUT_CPU_DATA;
  logic         OUT_CPU_ERR;

  int checks = 0;
  int errors = 0;

  // Scoreboard of {err, data}; an accepted request is queued one cycle later,
  // once it has actually entered the FIFO.
  logic [32:0] sb[$];
  logic        pend = 1'b0;
  logic [32:0] pend_word;
  logic [32:0] exp_word;

  localparam logic [127:0] LineA = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] LineB = 128'h89ABCDEF_01234567_11223344_55667788;

  cache_read_data_return dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .IN_REQ_VALID   (IN_REQ_VALID),
    .OUT_REQ_READY  (OUT_REQ_READY),
    .SIG_RAM_LOAD   (SIG_RAM_LOAD),
    .IN_ADDR_OFFSET (IN_ADDR_OFFSET),
    .IN_B_VAL       (IN_B_VAL),
    .IN_RAM_DATA    (IN_RAM_DATA),
    .IN_CACHE_DATA  (IN_CACHE_DATA),
    .OUT_CPU_VALID  (OUT_CPU_VALID),
    .IN_CPU_READY   (IN_CPU_READY),
    .OUT_CPU_DATA   (OUT_CPU_DATA),
    .OUT_CPU_ERR    (OUT_CPU_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [32:0] model(input logic src, input logic [3:0] off,
                                        input logic [3:0] bv, input logic [127:0] ram,
                                        input logic [127:0] cache);
    logic [127:0] ln;
    logic [31:0]  w;
    logic [31:0]  d;
    ln = src ? ram : cache;
    case (off[3:2])
      2'd0:    w = ln[31:0];
      2'd1:    w = ln[63:32];
      2'd2:    w = ln[95:64];
      default: w = ln[127:96];
    endcase
    case (bv)
`ifdef CACHE_READ_ALIGN_EN
      4'b0001: d = {24'h0, w[7:0]};
      4'b0010: d = {24'h0, w[15:8]};
      4'b0100: d = {24'h0, w[23:16]};
      4'b1000: d = {24'h0, w[31:24]};
      4'b0011: d = {16'h0, w[15:0]};
      4'b1100: d = {16'h0, w[31:16]};
`else
      4'b0001: d = {24'h0, w[7:0]};
      4'b0010: d = {16'h0, w[15:8], 8'h0};
      4'b0100: d = {8'h0, w[23:16], 16'h0};
      4'b1000: d = {w[31:24], 24'h0};
      4'b0011: d = {16'h0, w[15:0]};
      4'b1100: d = {w[31:16], 16'h0};
`endif
      4'b1111: d = w;
      default: return {1'b1, 32'h0};
    endcase
    return {1'b0, d};
  endfunction

  // Drives one cycle of inputs at the falling edge and settles; records the
  // expected response if the request will be accepted at the next rising edge.
  task automatic drive(input logic rst, input logic vld, input logic src,
                       input logic [3:0] off, input logic [3:0] bv,
                       input logic [127:0] ram, input logic [127:0] cache,
                       input logic cpu_rdy);
    @(negedge CLK);
    if (pend) sb.push_back(pend_word);
    pend = 1'b0;
    if (rst) sb.delete();
    RESET          = rst;
    IN_REQ_VALID   = vld;
    SIG_RAM_LOAD   = src;
    IN_ADDR_OFFSET = off;
    IN_B_VAL       = bv;
    IN_RAM_DATA    = ram;
    IN_CACHE_DATA  = cache;
    IN_CPU_READY   = cpu_rdy;
    #1;
    if (!rst && IN_REQ_VALID && OUT_REQ_READY) begin
      pend      = 1'b1;
      pend_word = model(src, off, bv, ram, cache);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'hF, '0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, '0, '0, 1'b0);
    checks += 4;
    if (OUT_CPU_VALID !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", OUT_CPU_VALID);
    end
    if (OUT_CPU_DATA !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 00000000", OUT_CPU_DATA);
    end
    if (OUT_CPU_ERR !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b expected 0", OUT_CPU_ERR);
    end
    if (OUT_REQ_READY !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", OUT_REQ_READY);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 10 && (sb.size() != 0 || pend || OUT_CPU_VALID); i++) begin
      drive(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, '0, '0, 1'b1);
      if (OUT_CPU_VALID && IN_CPU_READY) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL drain_extra: got %h expected no response",
                             {OUT_CPU_ERR, OUT_CPU_DATA});
        end else begin
          exp_word = sb.pop_front();
          if ({OUT_CPU_ERR, OUT_CPU_DATA} !== exp_word) begin
            errors++; $display("FAIL drain_resp: got %h expected %h",
                               {OUT_CPU_ERR, OUT_CPU_DATA}, exp_word);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0 || pend || OUT_CPU_VALID) begin
      errors++; $display("FAIL drain_timeout: got %0d left valid=%b expected 0 left valid=0",
                         sb.size(), OUT_CPU_VALID);
      sb.delete();
      pend = 1'b0;
    end
  endtask

  task automatic test_cache_hit();
    drive(1'b0, 1'b1, 1'b0, 4'b1000, 4'b1111, LineB, LineA, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, LineB, LineA, 1'b1);
    checks += 2;
    if (OUT_CPU_VALID !== 1'b1) begin
      errors++; $display("FAIL hit_latency: got valid=%b expected 1", OUT_CPU_VALID);
    end
    if ({OUT_CPU_ERR, OUT_CPU_DATA} !== {1'b0, 32'hCCCCCCCC}) begin
      errors++; $display("FAIL hit_word: got %h expected 0CCCCCCCC",
                         {OUT_CPU_ERR, OUT_CPU_DATA});
    end
    if (OUT_CPU_VALID && IN_CPU_READY) begin
      checks++;
      exp_word = sb.pop_front();
      if ({OUT_CPU_ERR, OUT_CPU_DATA} !== exp_word) begin
        errors++; $display("FAIL hit_sb: got %h expected %h", {OUT_CPU_ERR, OUT_CPU_DATA},
                           exp_word);
      end
    end
    test_drain();
  endtask

  task automatic test_refill_lane();
    logic [31:0] want;
`ifdef CACHE_READ_ALIGN_EN
    want = 32'h00000033;
`else
    want = 32'h00003300;
`endif
    drive(1'b0, 1'b1, 1'b1, 4'b0100, 4'b0010, LineB, LineA, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, LineB, LineA, 1'b1);
    checks++;
    if (OUT_CPU_VALID !== 1'b1 || OUT_CPU_ERR !== 1'b0 || OUT_CPU_DATA !== want) begin
      errors++; $display("FAIL refill_lane: got v=%b e=%b %h expected v=1 e=0 %h",
                         OUT_CPU_VALID, OUT_CPU_ERR, OUT_CPU_DATA, want);
    end
    if (OUT_CPU_VALID && IN_CPU_READY) void'(sb.pop_front());
    test_drain();
  endtask

  task automatic test_masks();
    logic [3:0] masks [10] = '{4'b0101, 4'b0000, 4'b0110, 4'b1110, 4'b1001,
                               4'b0001, 4'b0100, 4'b1000, 4'b0011, 4'b1100};
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, i[0], 4'(i * 4 + 1), masks[i], LineB, LineA, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, LineB, LineA, 1'b1);
      if (i < 2) begin
        checks++;
        if (OUT_CPU_ERR !== 1'b1 || OUT_CPU_DATA !== 32'h0) begin
          errors++; $display("FAIL illegal_mask_%b: got e=%b %h expected e=1 00000000",
                             masks[i], OUT_CPU_ERR, OUT_CPU_DATA);
        end
      end
      if (OUT_CPU_VALID && IN_CPU_READY) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL mask_sb_empty: got %h expected no response",
                             {OUT_CPU_ERR, OUT_CPU_DATA});
        end else begin
          exp_word = sb.pop_front();
          if ({OUT_CPU_ERR, OUT_CPU_DATA} !== exp_word) begin
            errors++; $display("FAIL mask_%b: got %h expected %h", masks[i],
                               {OUT_CPU_ERR, OUT_CPU_DATA}, exp_word);
          end
        end
      end
    end
    test_drain();
  endtask

  task automatic test_back_pressure();
    // cycle: valid, offset, cpu_ready, expected OUT_REQ_READY
    logic       vld [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] off [7] = '{4'h0, 4'h4, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0};
    logic       crd [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       rdy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, vld[i], 1'b0, off[i], 4'b1111, LineB, LineA, crd[i]);
      checks++;
      if (OUT_REQ_READY !== rdy[i]) begin
        errors++; $display("FAIL bp_ready_c%0d: got %b expected %b", i, OUT_REQ_READY, rdy[i]);
      end
      if (i == 2 || i == 3) begin
        checks++;
        if (OUT_CPU_VALID !== 1'b1 || OUT_CPU_DATA !== 32'hAAAAAAAA) begin
          errors++; $display("FAIL bp_hold_c%0d: got v=%b %h expected v=1 AAAAAAAA", i,
                             OUT_CPU_VALID, OUT_CPU_DATA);
        end
      end
      if (OUT_CPU_VALID && IN_CPU_READY) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_sb_empty: got %h expected no response",
                             {OUT_CPU_ERR, OUT_CPU_DATA});
        end else begin
          exp_word = sb.pop_front();
          if ({OUT_CPU_ERR, OUT_CPU_DATA} !== exp_word) begin
            errors++; $display("FAIL bp_order_c%0d: got %h expected %h", i,
                               {OUT_CPU_ERR, OUT_CPU_DATA}, exp_word);
          end
        end
      end
    end
    test_drain();
  endtask

  task automatic test_back_to_back();
    logic [3:0] legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    logic [127:0] ram;
    for (int i = 0; i < 10; i++) begin
      ram = {$urandom, $urandom, $urandom, $urandom};
      drive(1'b0, 1'b1, i[0], 4'($urandom_range(0, 15)), legal[$urandom_range(0, 6)],
            ram, LineA, 1'b1);
      checks++;
      if (OUT_REQ_READY !== 1'b1 || (i > 0 && OUT_CPU_VALID !== 1'b1)) begin
        errors++; $display("FAIL stream_c%0d: got ready=%b valid=%b expected ready=1 valid=%b",
                           i, OUT_REQ_READY, OUT_CPU_VALID, i > 0);
      end
      if (OUT_CPU_VALID && IN_CPU_READY) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL stream_sb_empty: got %h expected no response",
                             {OUT_CPU_ERR, OUT_CPU_DATA});
        end else begin
          exp_word = sb.pop_front();
          if ({OUT_CPU_ERR, OUT_CPU_DATA} !== exp_word) begin
            errors++; $display("FAIL stream_resp_c%0d: got %h expected %h", i,
                               {OUT_CPU_ERR, OUT_CPU_DATA}, exp_word);
          end
        end
      end
    end
    test_drain();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 1'b0, 4'h0, 4'b1111, LineB, LineA, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'h4, 4'b1111, LineB, LineA, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'h8, 4'b1111, LineB, LineA, 1'b0);
    checks++;
    if (OUT_REQ_READY !== 1'b0) begin
      errors++; $display("FAIL rmid_full: got ready=%b expected 0", OUT_REQ_READY);
    end
    drive(1'b1, 1'b1, 1'b0, 4'hC, 4'b1111, LineB, LineA, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'b1111, LineB, LineA, 1'b1);
    checks++;
    if ({OUT_CPU_VALID, OUT_CPU_ERR, OUT_REQ_READY} !== 3'b001 || OUT_CPU_DATA !== 32'h0) begin
      errors++; $display("FAIL rmid_clear: got v=%b e=%b r=%b %h expected v=0 e=0 r=1 00000000",
                         OUT_CPU_VALID, OUT_CPU_ERR, OUT_REQ_READY, OUT_CPU_DATA);
    end
    // Request alongside reset while the FIFO has room must also be dropped.
    drive(1'b1, 1'b1, 1'b0, 4'hC, 4'b1111, LineB, LineA, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'b1111, LineB, LineA, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'b1111, LineB, LineA, 1'b1);
    checks++;
    if (OUT_CPU_VALID !== 1'b0 || OUT_CPU_DATA !== 32'h0) begin
      errors++; $display("FAIL rmid_drop: got v=%b %h expected v=0 00000000",
                         OUT_CPU_VALID, OUT_CPU_DATA);
    end
  endtask

  initial begin
    RESET = 1'b1; IN_REQ_VALID = 1'b0; SIG_RAM_LOAD = 1'b0; IN_ADDR_OFFSET = '0;
    IN_B_VAL = '0; IN_RAM_DATA = '0; IN_CACHE_DATA = '0; IN_CPU_READY = 1'b0;
    test_reset();
    test_cache_hit();
    test_refill_lane();
    test_masks();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
